// File: rtl/fifo_umbrales.sv
// Synchronous FIFO with a registered read port, occupancy count, programmable
// almost-full/almost-empty thresholds and a sticky overflow/underflow flag.
module fifo_umbrales #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  input  logic [ADDR_WIDTH:0]   umbral_alto,
  input  logic [ADDR_WIDTH:0]   umbral_bajo,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  error
);

  localparam int DEPTH_I = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH = DEPTH_I[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem [DEPTH_I];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   alto_q;
  logic [ADDR_WIDTH:0]   bajo_q;

  logic push_ok;
  logic pop_ok;
  logic overflow;
  logic underflow;

  // Handshake: push/pop are single-cycle requests sampled at the rising edge;
  // a request is accepted or dropped in that same edge, never stalled. A pop
  // accepted at edge N presents its word with valid_out=1 after edge N only.
  always_comb begin
    pop_ok    = pop && (count != '0);
    push_ok   = push && ((count != DEPTH) || pop_ok);
    overflow  = push && !push_ok;
    underflow = pop && (count == '0);
  end

  always_comb begin
    empty        = (count == '0);
    full         = (count == DEPTH);
    almost_full  = reset && (count >= alto_q);
    almost_empty = !reset || (count <= bajo_q);
  end

  // Storage is never cleared; a full push+pop reads the old word at the
  // shared address because both sides use the pre-edge contents.
  always_ff @(posedge clk) begin
    if (reset && push_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      error     <= 1'b0;
      alto_q    <= umbral_alto;
      bajo_q    <= umbral_bajo;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
      valid_out <= pop_ok;
      if (push_ok && !pop_ok) begin
        count <= count + 1'b1;
      end else if (pop_ok && !push_ok) begin
        count <= count - 1'b1;
      end
      if (overflow || underflow) begin
        error <= 1'b1;
      end
    end
  end

endmodule
